// File: rtl/mem_pkg.sv
// Shared definitions for the processor-side memory access stage:
// memoryModule command encodings and the stage state encoding.
package mem_pkg;

   // memoryModule cntrl encodings; 2'b11 is reserved and never driven.
   localparam logic [1:0] MEM_NOP   = 2'b00;
   localparam logic [1:0] MEM_READ  = 2'b01;
   localparam logic [1:0] MEM_WRITE = 2'b10;

   // Stage state encoding.
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUSY = 2'b01,
      ST_RESP = 2'b10
   } state_t;

   // Select the memoryModule command for an accepted request.
   function automatic logic [1:0] op_cntrl(input logic is_write);
      logic [1:0] cmd;
      if (is_write) begin
         cmd = MEM_WRITE;
      end else begin
         cmd = MEM_READ;
      end
      return cmd;
   endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// Saturating cycle counter used to detect a memoryModule transaction that
// never returns dataReady. tc_o flags the final permitted BUSY cycle.
module mem_timeout_counter
   import mem_pkg::*;
#(
   parameter int TIMEOUT = 64
) (
   input  logic clk,
   input  logic clr,
   input  logic clear_i,
   input  logic enable_i,
   output logic tc_o
);

   // Smallest width able to hold TIMEOUT itself, so saturation never wraps.
   localparam int             CW     = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0]  TC_VAL = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0]  SAT    = CW'(TIMEOUT);
   localparam logic [CW-1:0]  ONE    = CW'(1);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   // Next count: clear wins, otherwise increment while enabled up to saturation.
   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (enable_i && (count_q != SAT)) begin
         count_d = count_q + ONE;
      end else begin
         count_d = count_q;
      end
   end

   // Count register with synchronous reset.
   always_ff @(posedge clk) begin
      if (clr) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign tc_o = (count_q == TC_VAL);

endmodule

// File: rtl/mem_access_stage.sv
// Processor-side memory stage sitting directly in front of memoryModule.
// Accepts one load/store at a time, holds the memoryModule inputs stable
// until dataReady, returns the result with a one-cycle strobe, and aborts
// transactions that hang longer than TIMEOUT cycles.
module mem_access_stage
   import mem_pkg::*;
#(
   parameter int ramWidth = 8,
   parameter int addrSize = 8,
   parameter int TIMEOUT  = 64
) (
   input  logic                clk,
   input  logic                clr,
   input  logic                req_valid,
   input  logic                req_write,
   input  logic                req_indirect,
   input  logic [addrSize-1:0] req_addr,
   input  logic [ramWidth-1:0] req_data,
   output logic                req_ready,
   output logic                stall,
   output logic                rsp_valid,
   output logic [ramWidth-1:0] rsp_data,
   output logic                err_timeout,
   output logic [1:0]          mem_cntrl,
   output logic [addrSize-1:0] mem_addr,
   output logic [ramWidth-1:0] mem_dataIn,
   output logic                mem_isIndirect,
   input  logic                mem_dataReady,
   input  logic [ramWidth-1:0] mem_dataOut
);

   state_t              state_q;
   logic                rsp_valid_q;
   logic [ramWidth-1:0] rsp_data_q;
   logic                err_timeout_q;
   logic [1:0]          mem_cntrl_q;
   logic [addrSize-1:0] mem_addr_q;
   logic [ramWidth-1:0] mem_dataIn_q;
   logic                mem_isIndirect_q;

   logic                tmo_clear_s;
   logic                tmo_enable_s;
   logic                tmo_tc_s;

   // The counter restarts on every IDLE cycle, so it is zero in the first BUSY cycle.
   assign tmo_clear_s  = (state_q == ST_IDLE);
   assign tmo_enable_s = (state_q == ST_BUSY);

   mem_timeout_counter #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk      (clk),
      .clr      (clr),
      .clear_i  (tmo_clear_s),
      .enable_i (tmo_enable_s),
      .tc_o     (tmo_tc_s)
   );

   // Request/response FSM; every memoryModule input and response output is registered here.
   always_ff @(posedge clk) begin
      if (clr) begin
         state_q          <= ST_IDLE;
         rsp_valid_q      <= 1'b0;
         rsp_data_q       <= '0;
         err_timeout_q    <= 1'b0;
         mem_cntrl_q      <= MEM_NOP;
         mem_addr_q       <= '0;
         mem_dataIn_q     <= '0;
         mem_isIndirect_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               rsp_valid_q <= 1'b0;
               if (req_valid) begin
                  state_q          <= ST_BUSY;
                  mem_cntrl_q      <= op_cntrl(req_write);
                  mem_addr_q       <= req_addr;
                  mem_dataIn_q     <= req_data;
                  mem_isIndirect_q <= req_indirect;
               end else begin
                  state_q     <= ST_IDLE;
                  mem_cntrl_q <= MEM_NOP;
               end
            end
            ST_BUSY: begin
               if (mem_dataReady) begin
                  // A store echoes its own data; a load returns the memory word.
                  if (mem_cntrl_q == MEM_WRITE) begin
                     rsp_data_q <= mem_dataIn_q;
                  end else begin
                     rsp_data_q <= mem_dataOut;
                  end
                  rsp_valid_q <= 1'b1;
                  mem_cntrl_q <= MEM_NOP;
                  state_q     <= ST_RESP;
               end else if (tmo_tc_s) begin
                  // Hung transaction: abandon it and report an empty response.
                  err_timeout_q <= 1'b1;
                  rsp_data_q    <= '0;
                  rsp_valid_q   <= 1'b1;
                  mem_cntrl_q   <= MEM_NOP;
                  state_q       <= ST_RESP;
               end else begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= ST_BUSY;
               end
            end
            ST_RESP: begin
               // One guaranteed NOP cycle before any new operation.
               rsp_valid_q <= 1'b0;
               mem_cntrl_q <= MEM_NOP;
               state_q     <= ST_IDLE;
            end
            default: begin
               rsp_valid_q <= 1'b0;
               mem_cntrl_q <= MEM_NOP;
               state_q     <= ST_IDLE;
            end
         endcase
      end
   end

   assign req_ready      = (state_q == ST_IDLE);
   assign stall          = (state_q == ST_BUSY) || (state_q == ST_RESP);
   assign rsp_valid      = rsp_valid_q;
   assign rsp_data       = rsp_data_q;
   assign err_timeout    = err_timeout_q;
   assign mem_cntrl      = mem_cntrl_q;
   assign mem_addr       = mem_addr_q;
   assign mem_dataIn     = mem_dataIn_q;
   assign mem_isIndirect = mem_isIndirect_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed, table-driven bench for mem_access_stage (TIMEOUT = 8).
// Each record gives the inputs present before a rising edge and the outputs
// expected just after it.
module tb_mem_access_stage;

   typedef struct packed {
      logic       clr;
      logic       v;
      logic       w;
      logic       ind;
      logic [7:0] a;
      logic [7:0] d;
      logic       dr;
      logic [7:0] dout;
   } in_t;

   typedef struct packed {
      logic       rdy;
      logic       stl;
      logic       rv;
      logic [7:0] rd;
      logic       err;
      logic [1:0] cn;
      logic [7:0] ad;
      logic [7:0] di;
      logic       ind;
   } out_t;

   typedef struct packed {
      in_t  i;
      out_t o;
   } vec_t;

   logic       clk = 1'b0;
   logic       clr, req_valid, req_write, req_indirect;
   logic [7:0] req_addr, req_data;
   logic       req_ready, stall, rsp_valid, err_timeout;
   logic [7:0] rsp_data;
   logic [1:0] mem_cntrl;
   logic [7:0] mem_addr, mem_dataIn;
   logic       mem_isIndirect, mem_dataReady;
   logic [7:0] mem_dataOut;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mem_access_stage #(
      .ramWidth (8),
      .addrSize (8),
      .TIMEOUT  (8)
   ) dut (
      .clk            (clk),
      .clr            (clr),
      .req_valid      (req_valid),
      .req_write      (req_write),
      .req_indirect   (req_indirect),
      .req_addr       (req_addr),
      .req_data       (req_data),
      .req_ready      (req_ready),
      .stall          (stall),
      .rsp_valid      (rsp_valid),
      .rsp_data       (rsp_data),
      .err_timeout    (err_timeout),
      .mem_cntrl      (mem_cntrl),
      .mem_addr       (mem_addr),
      .mem_dataIn     (mem_dataIn),
      .mem_isIndirect (mem_isIndirect),
      .mem_dataReady  (mem_dataReady),
      .mem_dataOut    (mem_dataOut)
   );

   function automatic in_t mk_in(input logic c, input logic v, input logic w, input logic ind,
                                 input logic [7:0] a, input logic [7:0] d,
                                 input logic dr, input logic [7:0] dout);
      return '{clr: c, v: v, w: w, ind: ind, a: a, d: d, dr: dr, dout: dout};
   endfunction

   function automatic out_t mk_out(input logic rdy, input logic stl, input logic rv,
                                   input logic [7:0] rd, input logic err, input logic [1:0] cn,
                                   input logic [7:0] ad, input logic [7:0] di, input logic ind);
      return '{rdy: rdy, stl: stl, rv: rv, rd: rd, err: err, cn: cn, ad: ad, di: di, ind: ind};
   endfunction

   function automatic in_t idle_in();
      return mk_in(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
   endfunction

   // Drive one input record, clock once, then compare every output.
   task automatic run(input string nm, input in_t i, input out_t e);
      out_t g;
      clr           = i.clr;
      req_valid     = i.v;
      req_write     = i.w;
      req_indirect  = i.ind;
      req_addr      = i.a;
      req_data      = i.d;
      mem_dataReady = i.dr;
      mem_dataOut   = i.dout;
      @(posedge clk);
      #1;
      g = mk_out(req_ready, stall, rsp_valid, rsp_data, err_timeout,
                 mem_cntrl, mem_addr, mem_dataIn, mem_isIndirect);
      n_vec++;
      if (g !== e) begin
         n_err++;
         $display("FAIL %s: got rdy=%b stall=%b rv=%b rd=%h err=%b cntrl=%b addr=%h din=%h ind=%b, want rdy=%b stall=%b rv=%b rd=%h err=%b cntrl=%b addr=%h din=%h ind=%b",
                  nm, g.rdy, g.stl, g.rv, g.rd, g.err, g.cn, g.ad, g.di, g.ind,
                  e.rdy, e.stl, e.rv, e.rd, e.err, e.cn, e.ad, e.di, e.ind);
      end
   endtask

   vec_t tbl [20];

   initial begin
      clr = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_indirect = 1'b0;
      req_addr = 8'h00; req_data = 8'h00; mem_dataReady = 1'b0; mem_dataOut = 8'h00;

      // reset
      tbl[0]  = '{mk_in(1'b1,1'b0,1'b0,1'b0,8'h00,8'h00,1'b0,8'h00), mk_out(1'b1,1'b0,1'b0,8'h00,1'b0,2'b00,8'h00,8'h00,1'b0)};
      // read 2A, dataReady seen at the end of the third BUSY cycle
      tbl[1]  = '{mk_in(1'b0,1'b1,1'b0,1'b0,8'h2A,8'h00,1'b0,8'h00), mk_out(1'b0,1'b1,1'b0,8'h00,1'b0,2'b01,8'h2A,8'h00,1'b0)};
      tbl[2]  = '{idle_in(),                                         mk_out(1'b0,1'b1,1'b0,8'h00,1'b0,2'b01,8'h2A,8'h00,1'b0)};
      tbl[3]  = '{idle_in(),                                         mk_out(1'b0,1'b1,1'b0,8'h00,1'b0,2'b01,8'h2A,8'h00,1'b0)};
      tbl[4]  = '{mk_in(1'b0,1'b0,1'b0,1'b0,8'h00,8'h00,1'b1,8'h5C), mk_out(1'b0,1'b1,1'b1,8'h5C,1'b0,2'b00,8'h2A,8'h00,1'b0)};
      // back in IDLE; a stray dataReady is ignored
      tbl[5]  = '{mk_in(1'b0,1'b0,1'b0,1'b0,8'h00,8'h00,1'b1,8'hFF), mk_out(1'b1,1'b0,1'b0,8'h5C,1'b0,2'b00,8'h2A,8'h00,1'b0)};
      // indirect write 10 <- A5, dataReady after one cycle; memory data ignored for stores
      tbl[6]  = '{mk_in(1'b0,1'b1,1'b1,1'b1,8'h10,8'hA5,1'b0,8'h00), mk_out(1'b0,1'b1,1'b0,8'h5C,1'b0,2'b10,8'h10,8'hA5,1'b1)};
      tbl[7]  = '{mk_in(1'b0,1'b0,1'b0,1'b0,8'h00,8'h00,1'b1,8'h33), mk_out(1'b0,1'b1,1'b1,8'hA5,1'b0,2'b00,8'h10,8'hA5,1'b1)};
      tbl[8]  = '{idle_in(),                                         mk_out(1'b1,1'b0,1'b0,8'hA5,1'b0,2'b00,8'h10,8'hA5,1'b1)};
      // back-to-back reads with req_valid held high
      tbl[9]  = '{mk_in(1'b0,1'b1,1'b0,1'b0,8'h40,8'h00,1'b0,8'h00), mk_out(1'b0,1'b1,1'b0,8'hA5,1'b0,2'b01,8'h40,8'h00,1'b0)};
      tbl[10] = '{mk_in(1'b0,1'b1,1'b0,1'b0,8'h41,8'h00,1'b1,8'hE1), mk_out(1'b0,1'b1,1'b1,8'hE1,1'b0,2'b00,8'h40,8'h00,1'b0)};
      tbl[11] = '{mk_in(1'b0,1'b1,1'b0,1'b0,8'h41,8'h00,1'b0,8'h00), mk_out(1'b1,1'b0,1'b0,8'hE1,1'b0,2'b00,8'h40,8'h00,1'b0)};
      tbl[12] = '{mk_in(1'b0,1'b1,1'b0,1'b0,8'h41,8'h00,1'b0,8'h00), mk_out(1'b0,1'b1,1'b0,8'hE1,1'b0,2'b01,8'h41,8'h00,1'b0)};
      tbl[13] = '{mk_in(1'b0,1'b0,1'b0,1'b0,8'h00,8'h00,1'b1,8'hE2), mk_out(1'b0,1'b1,1'b1,8'hE2,1'b0,2'b00,8'h41,8'h00,1'b0)};
      tbl[14] = '{idle_in(),                                         mk_out(1'b1,1'b0,1'b0,8'hE2,1'b0,2'b00,8'h41,8'h00,1'b0)};
      // clr during the second BUSY cycle of a write, then a late dataReady
      tbl[15] = '{mk_in(1'b0,1'b1,1'b1,1'b1,8'hC3,8'h3C,1'b0,8'h00), mk_out(1'b0,1'b1,1'b0,8'hE2,1'b0,2'b10,8'hC3,8'h3C,1'b1)};
      tbl[16] = '{idle_in(),                                         mk_out(1'b0,1'b1,1'b0,8'hE2,1'b0,2'b10,8'hC3,8'h3C,1'b1)};
      tbl[17] = '{mk_in(1'b1,1'b0,1'b0,1'b0,8'h00,8'h00,1'b0,8'h00), mk_out(1'b1,1'b0,1'b0,8'h00,1'b0,2'b00,8'h00,8'h00,1'b0)};
      tbl[18] = '{mk_in(1'b0,1'b0,1'b0,1'b0,8'h00,8'h00,1'b1,8'h99), mk_out(1'b1,1'b0,1'b0,8'h00,1'b0,2'b00,8'h00,8'h00,1'b0)};
      tbl[19] = '{idle_in(),                                         mk_out(1'b1,1'b0,1'b0,8'h00,1'b0,2'b00,8'h00,8'h00,1'b0)};

      for (int k = 0; k < 20; k++) begin
         run($sformatf("vec%0d", k), tbl[k].i, tbl[k].o);
      end

      // normal read so that the timeout's zero response is distinguishable
      run("rd66_acc",  mk_in(1'b0,1'b1,1'b0,1'b0,8'h66,8'h00,1'b0,8'h00), mk_out(1'b0,1'b1,1'b0,8'h00,1'b0,2'b01,8'h66,8'h00,1'b0));
      run("rd66_resp", mk_in(1'b0,1'b0,1'b0,1'b0,8'h00,8'h00,1'b1,8'hC7), mk_out(1'b0,1'b1,1'b1,8'hC7,1'b0,2'b00,8'h66,8'h00,1'b0));
      run("rd66_idle", idle_in(),                                         mk_out(1'b1,1'b0,1'b0,8'hC7,1'b0,2'b00,8'h66,8'h00,1'b0));

      // timeout: 8 BUSY cycles without dataReady, then abort
      run("tmo_busy1", mk_in(1'b0,1'b1,1'b0,1'b0,8'h55,8'h00,1'b0,8'h00), mk_out(1'b0,1'b1,1'b0,8'hC7,1'b0,2'b01,8'h55,8'h00,1'b0));
      for (int k = 2; k <= 8; k++) begin
         run($sformatf("tmo_busy%0d", k), idle_in(), mk_out(1'b0,1'b1,1'b0,8'hC7,1'b0,2'b01,8'h55,8'h00,1'b0));
      end
      run("tmo_resp",  idle_in(), mk_out(1'b0,1'b1,1'b1,8'h00,1'b1,2'b00,8'h55,8'h00,1'b0));
      run("tmo_idle",  idle_in(), mk_out(1'b1,1'b0,1'b0,8'h00,1'b1,2'b00,8'h55,8'h00,1'b0));
      // following request completes normally, error stays sticky
      run("post_acc",  mk_in(1'b0,1'b1,1'b0,1'b0,8'h88,8'h00,1'b0,8'h00), mk_out(1'b0,1'b1,1'b0,8'h00,1'b1,2'b01,8'h88,8'h00,1'b0));
      run("post_resp", mk_in(1'b0,1'b0,1'b0,1'b0,8'h00,8'h00,1'b1,8'hD4), mk_out(1'b0,1'b1,1'b1,8'hD4,1'b1,2'b00,8'h88,8'h00,1'b0));
      run("post_idle", idle_in(),                                         mk_out(1'b1,1'b0,1'b0,8'hD4,1'b1,2'b00,8'h88,8'h00,1'b0));
      run("err_clr",   mk_in(1'b1,1'b0,1'b0,1'b0,8'h00,8'h00,1'b0,8'h00), mk_out(1'b1,1'b0,1'b0,8'h00,1'b0,2'b00,8'h00,8'h00,1'b0));

      // dataReady on the same edge as the timeout: normal response wins
      run("race_busy1", mk_in(1'b0,1'b1,1'b0,1'b0,8'h77,8'h00,1'b0,8'h00), mk_out(1'b0,1'b1,1'b0,8'h00,1'b0,2'b01,8'h77,8'h00,1'b0));
      for (int k = 2; k <= 8; k++) begin
         run($sformatf("race_busy%0d", k), idle_in(), mk_out(1'b0,1'b1,1'b0,8'h00,1'b0,2'b01,8'h77,8'h00,1'b0));
      end
      run("race_resp", mk_in(1'b0,1'b0,1'b0,1'b0,8'h00,8'h00,1'b1,8'hAB), mk_out(1'b0,1'b1,1'b1,8'hAB,1'b0,2'b00,8'h77,8'h00,1'b0));
      run("race_idle", idle_in(),                                         mk_out(1'b1,1'b0,1'b0,8'hAB,1'b0,2'b00,8'h77,8'h00,1'b0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
